// File: rtl/egg_job_scheduler_pkg.sv
// ============================================================================
//  Module      : trinity_sched_pkg
//  Description : Shared types and constants for the egg job scheduler:
//                FSM state encoding, watchdog counter width helper and the
//                default header/hash widths shared with egg_core/needle_final.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trinity_sched_pkg;

    // Default datapath widths, kept identical to egg_core and needle_final
    localparam int unsigned HDR_W_DEFAULT  = 512;
    localparam int unsigned HASH_W_DEFAULT = 256;

    // Scheduler job sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    // Bits needed to count 0 .. cycles-1 (at least one bit)
    function automatic int unsigned wdog_cnt_w(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/egg_job_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Grants the first valid requester at or
//                after ptr (wrapping). Produces a one-hot grant, the binary
//                index of the winner and an any-grant flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    // Scan requesters starting at ptr; the first valid one wins
    always_comb begin
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % N_REQ);
            if (!grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/egg_job_scheduler.sv
// ============================================================================
//  Module      : egg_job_scheduler
//  Description : Shares one egg_core mining engine between N_REQ requesters.
//                Round-robin grant, start/wait-done sequencing of the core,
//                strict unsigned compare of the result hash against the target
//                latched at grant, and one tagged response per job.
//                Optional watchdog: define EGG_SCHED_WATCHDOG_EN to abort jobs
//                whose core does not finish within WDOG_CYCLES WAIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module egg_job_scheduler
    import trinity_sched_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int HDR_W       = HDR_W_DEFAULT,
    parameter  int HASH_W      = HASH_W_DEFAULT,
    parameter  int WDOG_CYCLES = 1024,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*HDR_W-1:0] req_header,
    input  logic [HASH_W-1:0]      cfg_target,
    output logic                   core_start,
    output logic [HDR_W-1:0]       core_header,
    input  logic                   core_done,
    input  logic [HASH_W-1:0]      core_hash,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_hit,
    output logic [HASH_W-1:0]      rsp_hash,
    output logic                   rsp_timeout,
    output logic                   busy
);

    sched_state_t      state;
    logic [ID_W-1:0]   rr_ptr;
    logic [HASH_W-1:0] target_q;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic [HDR_W-1:0]  hdr_sel;
    logic [ID_W-1:0]   ptr_next;
    logic              wdog_expire;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Grants are only offered while no job is in flight
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    // Priority moves to the requester just after the winner
    assign ptr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Select the header of the granted requester
    always_comb begin
        hdr_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                hdr_sel = req_header[i*HDR_W +: HDR_W];
            end
        end
    end

`ifdef EGG_SCHED_WATCHDOG_EN
    localparam int unsigned WDOG_W = wdog_cnt_w(WDOG_CYCLES);

    logic [WDOG_W-1:0] wdog_cnt;

    // WAIT-cycle counter; held at zero outside WAIT so every entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign wdog_expire = (state == ST_WAIT) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    // Without the watchdog WAIT lasts until the core reports done
    assign wdog_expire = 1'b0;
`endif

    // Job sequencing FSM with registered core and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            target_q    <= '0;
            core_start  <= 1'b0;
            core_header <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_hit     <= 1'b0;
            rsp_hash    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        core_header <= hdr_sel;
                        rsp_id      <= grant_id;
                        target_q    <= cfg_target;
                        rr_ptr      <= ptr_next;
                        core_start  <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    // core_done is deliberately ignored during the start pulse
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving in the expiry cycle still yields a normal result
                    if (core_done) begin
                        rsp_hash    <= core_hash;
                        rsp_hit     <= (core_hash < target_q);
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (wdog_expire) begin
                        rsp_hash    <= '0;
                        rsp_hit     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_egg_job_scheduler.sv
// ============================================================================
//  Module      : tb_egg_job_scheduler
//  Description : Directed self-checking bench for egg_job_scheduler. The core
//                is modelled by driving core_done/core_hash by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_egg_job_scheduler;

    localparam int N_REQ  = 4;
    localparam int HDR_W  = 512;
    localparam int HASH_W = 256;
    localparam int ID_W   = 2;
    localparam int CW     = 512;

    localparam logic [HASH_W-1:0] TGT  = {32'h0000_1000, 224'h0};
    localparam logic [HASH_W-1:0] ALL1 = '1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*HDR_W-1:0] req_header;
    logic [HASH_W-1:0]      cfg_target;
    logic                   core_start;
    logic [HDR_W-1:0]       core_header;
    logic                   core_done;
    logic [HASH_W-1:0]      core_hash;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_hit;
    logic [HASH_W-1:0]      rsp_hash;
    logic                   rsp_timeout;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    egg_job_scheduler #(
        .N_REQ       (N_REQ),
        .HDR_W       (HDR_W),
        .HASH_W      (HASH_W),
        .WDOG_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_header  (req_header),
        .cfg_target  (cfg_target),
        .core_start  (core_start),
        .core_header (core_header),
        .core_done   (core_done),
        .core_hash   (core_hash),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_hit     (rsp_hit),
        .rsp_hash    (rsp_hash),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HDR_W-1:0] hdr_of(input int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(i);
        return {16{w}};
    endfunction

    // Offer a job at a negedge in IDLE; returns at the START-cycle negedge
    task automatic grant_job(input logic [N_REQ-1:0] mask, input int exp_id, input bit hold);
        logic [N_REQ-1:0] exp_rdy;
        exp_rdy         = '0;
        exp_rdy[exp_id] = 1'b1;
        req_valid  = mask;
        cfg_target = TGT;
        #1;
        check_eq("req_ready_grant", CW'(req_ready), CW'(exp_rdy));
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = '0;
        check_eq("core_start_pulse", CW'(core_start), CW'(1'b1));
        check_eq("req_ready_busy", CW'(req_ready), CW'(0));
        check_eq("core_header", CW'(core_header), CW'(hdr_of(exp_id)));
    endtask

    // From the START negedge: core finishes delay cycles later; ends in RESP
    task automatic finish_core(input int delay, input logic [HASH_W-1:0] h);
        @(negedge clk);
        check_eq("core_start_len", CW'(core_start), CW'(1'b0));
        repeat (delay - 2) @(negedge clk);
        core_done = 1'b1;
        core_hash = h;
        @(negedge clk);
        core_done = 1'b0;
        core_hash = '0;
    endtask

    task automatic check_resp(input int id, input bit hit, input logic [HASH_W-1:0] h, input bit to);
        check_eq("rsp_valid", CW'(rsp_valid), CW'(1'b1));
        check_eq("rsp_id", CW'(rsp_id), CW'(id));
        check_eq("rsp_hit", CW'(rsp_hit), CW'(hit));
        check_eq("rsp_hash", CW'(rsp_hash), CW'(h));
        check_eq("rsp_timeout", CW'(rsp_timeout), CW'(to));
    endtask

    task automatic accept_resp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", CW'(rsp_valid), CW'(1'b0));
        check_eq("busy_idle", CW'(busy), CW'(1'b0));
    endtask

    initial begin
        bit stable;
        rst        = 1'b1;
        req_valid  = '0;
        cfg_target = '0;
        core_done  = 1'b0;
        core_hash  = '0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_header[i*HDR_W +: HDR_W] = hdr_of(i);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", CW'(busy), CW'(0));
        check_eq("rst_core_start", CW'(core_start), CW'(0));
        check_eq("rst_core_header", CW'(core_header), CW'(0));
        check_eq("rst_rsp_valid", CW'(rsp_valid), CW'(0));
        check_eq("rst_rsp_fields", CW'({rsp_id, rsp_hit, rsp_timeout}), CW'(0));
        check_eq("rst_rsp_hash", CW'(rsp_hash), CW'(0));
        check_eq("rst_req_ready", CW'(req_ready), CW'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single job from requester 1, hash just below target
        grant_job(4'b0010, 1, 1'b0);
        finish_core(10, TGT - 1);
        check_resp(1, 1'b1, TGT - 1, 1'b0);
        accept_resp();

        // Compare boundaries (pointer now 2, requester 0 wins by wrap)
        grant_job(4'b0001, 0, 1'b0);
        finish_core(3, TGT);
        check_resp(0, 1'b0, TGT, 1'b0);
        accept_resp();
        grant_job(4'b0001, 0, 1'b0);
        finish_core(3, '0);
        check_resp(0, 1'b1, '0, 1'b0);
        accept_resp();
        grant_job(4'b0001, 0, 1'b0);
        finish_core(3, ALL1);
        check_resp(0, 1'b0, ALL1, 1'b0);
        accept_resp();

        // Backpressure: requester 2 kept valid while the response is stalled
        grant_job(4'b0100, 2, 1'b1);
        finish_core(4, TGT - 5);
        check_resp(2, 1'b1, TGT - 5, 1'b0);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hash !== TGT - 5 || rsp_id !== 2'd2 ||
                rsp_hit !== 1'b1 || req_ready !== 4'b0 || core_start !== 1'b0)
                stable = 1'b0;
        end
        check_eq("bp_stable", CW'(stable), CW'(1'b1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_rsp_drop", CW'(rsp_valid), CW'(1'b0));
        check_eq("bp_next_grant", CW'(req_ready), CW'(4'b0100));
        req_valid = '0;
        @(negedge clk);
        check_eq("bp_no_job", CW'(busy), CW'(1'b0));

        // Reset in WAIT drops the job (pointer is 3 here)
        grant_job(4'b1000, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("wait_busy", CW'(busy), CW'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", CW'(busy), CW'(0));
        check_eq("midrst_rsp_valid", CW'(rsp_valid), CW'(0));
        core_done = 1'b1;
        core_hash = '0;
        @(negedge clk);
        core_done = 1'b0;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        check_eq("midrst_no_rsp", CW'(stable), CW'(1'b1));

        // Fairness with all requesters held valid; first grant proves rr_ptr=0
        for (int j = 0; j < 8; j++) begin
            grant_job(4'b1111, j % 4, 1'b1);
            if (j % 2 == 0) begin
                finish_core(2 + j, TGT + HASH_W'(j));
                check_resp(j % 4, 1'b0, TGT + HASH_W'(j), 1'b0);
            end else begin
                finish_core(2 + j, HASH_W'(j));
                check_resp(j % 4, 1'b1, HASH_W'(j), 1'b0);
            end
            accept_resp();
        end
        req_valid = '0;
        @(negedge clk);

`ifdef EGG_SCHED_WATCHDOG_EN
        // Watchdog: core never completes, 16 WAIT cycles then timeout response
        grant_job(4'b0001, 0, 1'b0);
        repeat (16) @(negedge clk);
        check_eq("wdog_not_yet", CW'(rsp_valid), CW'(1'b0));
        @(negedge clk);
        check_resp(0, 1'b0, '0, 1'b1);
        core_done = 1'b1;
        core_hash = TGT - 1;
        @(negedge clk);
        core_done = 1'b0;
        core_hash = '0;
        check_resp(0, 1'b0, '0, 1'b1);
        accept_resp();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
